// File: rtl/oqpsk_bit_feeder.sv
// oqpsk_bit_feeder: word FIFO feeding an MSB-first serializer behind a 4-phase
// REQ/ACK bit handshake towards an OQPSK modulator.
// Optional feature macro: OQPSK_BIT_FEEDER_PRBS_EN. When it is defined, underrun
// idle bits come from a PRBS-9 generator (x^9+x^5+1). Otherwise idle bits are 0.
// Handshake: the modulator raises req. Once req is sampled high in IDLE, ack and
// bit_out update together on the next edge, and bit_out is valid while ack=1.
// ack stays high until req is sampled low. ack then falls on the following edge.
// dbg_state exposes the handshake FSM state (0=IDLE, 1=ACKED).
module oqpsk_bit_feeder #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       req,
  output logic                       bit_out,
  output logic                       ack,
  output logic                       overflow,
  output logic                       underrun,
  output logic                       dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE = 1'b0, ACKED = 1'b1} state_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic             ack_q, ack_d, bit_q, bit_d;
  logic             ovf_q, ovf_d, und_q, und_d;
  logic             push, load, und_ack, idle_bit;

  assign full      = (level_q == (AW+1)'(DEPTH));
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign ack       = ack_q;
  assign bit_out   = bit_q;
  assign overflow  = ovf_q;
  assign underrun  = und_q;
  assign dbg_state = state_q;

`ifdef OQPSK_BIT_FEEDER_PRBS_EN
  logic [8:0] prbs_q, prbs_d;

  // The PRBS advances only when an underrun is acknowledged. Its MSB is the idle bit.
  always_comb begin
    prbs_d = prbs_q;
    if (und_ack) prbs_d = {prbs_q[7:0], prbs_q[8] ^ prbs_q[4]};
  end

  // PRBS register with its all-ones seed applied on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prbs_q <= 9'h1FF;
    else        prbs_q <= prbs_d;
  end

  assign idle_bit = prbs_q[8];
`else
  assign idle_bit = 1'b0;
`endif

  // Next-state logic for the FIFO, the serializer, the handshake FSM and the flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    ack_d    = ack_q;
    bit_d    = bit_q;
    ovf_d    = ovf_q;
    und_d    = und_q;
    und_ack  = 1'b0;

    // Writes ignore en. full is taken from the registered level, so a word
    // written while full is dropped even if a pop frees a slot on the same edge.
    push = wr_en && !full;
    // en=0 freezes the serializer, so no load can happen while it is low.
    load = en && (cnt_q == '0) && !empty;

    if (!en) begin
      state_d = IDLE;
      ack_d   = 1'b0;
      ovf_d   = 1'b0;
      und_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_d = ACKED;
            ack_d   = 1'b1;
            if (cnt_q != '0) begin
              bit_d = sr_q[WIDTH-1];
              sr_d  = {sr_q[WIDTH-2:0], 1'b0};
              cnt_d = cnt_q - 1'b1;
            end else begin
              // A load that happens in this same cycle does not serve the request.
              bit_d   = idle_bit;
              und_d   = 1'b1;
              und_ack = 1'b1;
            end
          end
        end
        ACKED: begin
          if (!req) begin
            state_d = IDLE;
            ack_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A new overflow takes priority over the clear that en=0 applies.
    if (wr_en && full) ovf_d = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (load) begin
      sr_d     = mem_q[rd_ptr_q];
      cnt_d    = CW'(WIDTH);
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !load)      level_d = level_q + 1'b1;
    else if (!push && load) level_d = level_q - 1'b1;
  end

  // FIFO storage. It has no reset because the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // All control state, cleared asynchronously so no queued or partial word survives reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      bit_q    <= 1'b0;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      ack_q    <= ack_d;
      bit_q    <= bit_d;
      ovf_q    <= ovf_d;
      und_q    <= und_d;
    end
  end

endmodule

// File: tb/tb_oqpsk_bit_feeder.sv
// Directed testbench for oqpsk_bit_feeder (DEPTH=4, WIDTH=32).
// Build with OQPSK_BIT_FEEDER_PRBS_EN defined to expect PRBS-9 idle bits.
module tb_oqpsk_bit_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full, empty, req, bit_out, ack, overflow, underrun, dbg_state;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  // Expected idle bits for the first three underruns after reset (MSB first).
  // PRBS-9 from 1FF gives MSBs 1 (1FF), 1 (1FE), 1 (1FC).
`ifdef OQPSK_BIT_FEEDER_PRBS_EN
  logic [2:0] idle_exp = 3'b111;
`else
  logic [2:0] idle_exp = 3'b000;
`endif

  oqpsk_bit_feeder #(.DEPTH(4), .WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .req       (req),
    .bit_out   (bit_out),
    .ack       (ack),
    .overflow  (overflow),
    .underrun  (underrun),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"},  32'(full), 32'd0);
    chk({tag, "_ack"},   32'(ack), 32'd0);
    chk({tag, "_bit"},   32'(bit_out), 32'd0);
    chk({tag, "_ovf"},   32'(overflow), 32'd0);
    chk({tag, "_und"},   32'(underrun), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // Reset is asserted and released between clock edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Write one word. The push is seen on the next edge.
  task automatic write_word(input logic [31:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // One full 4-phase transfer. It checks that ack lags req by one edge and returns the bit.
  task automatic get_bit(input string tag, output logic b);
    req = 1'b1;
    chk({tag, "_ack_pre"}, 32'(ack), 32'd0);
    tick();
    chk({tag, "_ack_rise"}, 32'(ack), 32'd1);
    b = bit_out;
    req = 1'b0;
    tick();
    chk({tag, "_ack_fall"}, 32'(ack), 32'd0);
  endtask

  // Driver sequence and checks
  initial begin
    logic        b;
    logic [31:0] w, word;
    rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_data = '0; req = 1'b0;
    #12;
    chk_reset_vals("por");
    rst_n = 1'b1;
    tick();

    // Underruns on an empty FIFO: ack still asserts, and bit_out is the idle bit
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      get_bit("und", b);
      chk("und_bit", 32'(b), 32'(idle_exp[2-i]));
      chk("und_flag", 32'(underrun), 32'd1);
    end

    // Drop en while ack=1. Flags clear, and the serializer position is preserved.
    write_word(32'hB0000000);
    tick();  // load
    chk("en_empty_after_load", 32'(empty), 32'd1);
    get_bit("en_b0", b);
    chk("en_b0_val", 32'(b), 32'd1);
    req = 1'b1;
    tick();
    chk("en_ack_hi", 32'(ack), 32'd1);
    chk("en_b1_val", 32'(bit_out), 32'd0);
    chk("en_und_before", 32'(underrun), 32'd1);
    en = 1'b0;
    req = 1'b0;
    tick();
    chk("en_ack_drop", 32'(ack), 32'd0);
    chk("en_und_clr", 32'(underrun), 32'd0);
    chk("en_bit_hold", 32'(bit_out), 32'd0);
    chk("en_state", 32'(dbg_state), 32'd0);
    tick();
    en = 1'b1;
    get_bit("en_b2", b); chk("en_b2_val", 32'(b), 32'd1);
    get_bit("en_b3", b); chk("en_b3_val", 32'(b), 32'd1);
    get_bit("en_b4", b); chk("en_b4_val", 32'(b), 32'd0);
    chk("en_und_stay0", 32'(underrun), 32'd0);

    // A full word is sent MSB first, and an underrun follows it
    do_reset();
    chk_reset_vals("rst1");
    tick();
    write_word(32'hA5000001);
    chk("w_level1", 32'(level), 32'd1);
    chk("w_empty0", 32'(empty), 32'd0);
    tick();  // load
    chk("w_empty_load", 32'(empty), 32'd1);
    chk("w_level_load", 32'(level), 32'd0);
    w = 32'hA5000001;
    for (int i = 31; i >= 0; i--) begin
      get_bit("w", b);
      chk($sformatf("w_bit%0d", i), 32'(b), 32'(w[i]));
    end
    chk("w_no_und", 32'(underrun), 32'd0);
    get_bit("w_tail", b);
    chk("w_tail_bit", 32'(b), 32'(idle_exp[2]));
    chk("w_tail_und", 32'(underrun), 32'd1);

    // Holding req high gives a single ack and consumes exactly one bit
    do_reset();
    tick();
    write_word(32'hA0000000);
    tick();
    req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_ack", 32'(ack), 32'd1);
      chk("hold_bit", 32'(bit_out), 32'd1);
    end
    req = 1'b0;
    tick();
    chk("hold_ack_fall", 32'(ack), 32'd0);
    get_bit("hold_n1", b); chk("hold_n1_val", 32'(b), 32'd0);
    get_bit("hold_n2", b); chk("hold_n2_val", 32'(b), 32'd1);

    // Overflow with en=0. The fifth word is dropped and never emitted.
    do_reset();
    tick();
    en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      write_word(32'h11111111 * k);
      chk($sformatf("ovf_level%0d", k), 32'(level), 32'(k));
    end
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_pre", 32'(overflow), 32'd0);
    write_word(32'h55555555);
    chk("ovf_level_cap", 32'(level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    en = 1'b1;
    tick();  // load of word 1
    chk("ovf_level_pop", 32'(level), 32'd3);
    chk("ovf_full_clr", 32'(full), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      word = '0;
      for (int i = 0; i < 32; i++) begin
        get_bit("ovf_drain", b);
        word = {word[30:0], b};
      end
      chk($sformatf("ovf_word%0d", k), word, 32'h11111111 * k);
    end
    chk("ovf_no_und", 32'(underrun), 32'd0);
    get_bit("ovf_tail", b);
    chk("ovf_tail_bit", 32'(b), 32'(idle_exp[2]));
    chk("ovf_tail_und", 32'(underrun), 32'd1);

    // Asynchronous reset in the middle of a word discards all data
    do_reset();
    tick();
    write_word(32'hFFE00000);
    write_word(32'h12345678);  // the first word loads on this edge
    chk("ar_level", 32'(level), 32'd1);
    for (int i = 0; i < 10; i++) begin
      get_bit("ar", b);
      chk("ar_bit", 32'(b), 32'd1);
    end
    req = 1'b1;
    tick();
    chk("ar_ack11", 32'(ack), 32'd1);
    chk("ar_bit11", 32'(bit_out), 32'd1);
    req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("ar_async");
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    chk("ar_no_load", 32'(level), 32'd0);
    get_bit("ar_after", b);
    chk("ar_after_bit", 32'(b), 32'(idle_exp[2]));
    chk("ar_after_und", 32'(underrun), 32'd1);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
